// File: rtl/aux_ocm_writer_if.sv
// Sample stream in, OCM write port out.
// master = writer side, slave = source/memory side.
interface aux_ocm_writer_if #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 17,
  parameter int CHANNELS = 2
);
  logic                       in_dv;
  logic [CHANNELS*DATA_W-1:0] in_data;
  logic                       in_ready;
  logic [DATA_W-1:0]          ocm1_writedata;
  logic [ADDR_W-1:0]          ocm1_addr;
  logic                       ocm1_chip;
  logic                       ocm1_clk_enab;
  logic                       ocm1_write;

  modport master (
    input  in_dv,
    input  in_data,
    output in_ready,
    output ocm1_writedata,
    output ocm1_addr,
    output ocm1_chip,
    output ocm1_clk_enab,
    output ocm1_write
  );

  modport slave (
    output in_dv,
    output in_data,
    input  in_ready,
    input  ocm1_writedata,
    input  ocm1_addr,
    input  ocm1_chip,
    input  ocm1_clk_enab,
    input  ocm1_write
  );
endinterface

// File: rtl/aux_ocm_writer.sv
// Captures a frame of multi-lane samples, then drains it to OCM
// channel-major; optional zeroing pass before capture.
module aux_ocm_writer #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 17,
  parameter int CHANNELS    = 2,
  parameter int FRAME_LEN   = 16,
  parameter int CLEAR_WORDS = 4001,
  parameter int BASE_ADDR   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                clear_en,
  aux_ocm_writer_if.master    bus,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [15:0]         count
);

  localparam int TOTAL  = CHANNELS * FRAME_LEN;
  localparam int IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int SLOT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CLR_W  = (CLEAR_WORDS > 1) ? $clog2(CLEAR_WORDS) : 1;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic                ovf_q, ovf_d;
  logic [15:0]         count_q, count_d;
  logic [CLR_W-1:0]    clr_q, clr_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [IDX_W-1:0]    rd_q, rd_d;
  logic                chip_q;
  logic                busy_q;
  logic                done_q;
  logic                rdy_q;
  logic                issue;
  logic                cap_fire;
  logic [DATA_W-1:0]   lane0;

  // Laid out channel-major so the drain is a plain linear read
  logic [DATA_W-1:0]   smp_q [TOTAL];

  assign cap_fire = (state_q == S_CAPTURE) && bus.in_dv;
  assign lane0    = bus.in_data[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (cap_fire) begin
      for (int c = 0; c < CHANNELS; c++) begin
        smp_q[IDX_W'(c*FRAME_LEN + int'(slot_q))] <=
          bus.in_data[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    ovf_d   = ovf_q;
    count_d = count_q;
    clr_d   = clr_q;
    slot_d  = slot_q;
    rd_d    = rd_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          slot_d = '0;
          if (clear_en) begin
            state_d = S_CLEAR;
            ptr_d   = BASE_A;
            count_d = '0;
            ovf_d   = 1'b0;
            clr_d   = '0;
            wr_d    = 1'b1;
            addr_d  = BASE_A;
            wdata_d = '0;
          end else begin
            state_d = S_CAPTURE;
          end
        end
      end
      S_CLEAR: begin
        if (clr_q == CLR_W'(CLEAR_WORDS-1)) begin
          state_d = S_CAPTURE;
          ptr_d   = BASE_A;
        end else begin
          clr_d   = clr_q + CLR_W'(1);
          wr_d    = 1'b1;
          addr_d  = BASE_A + ADDR_W'(clr_d);
          wdata_d = '0;
        end
      end
      S_CAPTURE: begin
        if (bus.in_dv) begin
          if (slot_q == SLOT_W'(FRAME_LEN-1)) begin
            // First word leaves with the last sample's edge
            state_d = S_DRAIN;
            rd_d    = '0;
            issue   = 1'b1;
            if (FRAME_LEN == 1) wdata_d = lane0;
            else                wdata_d = smp_q[0];
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (rd_q == IDX_W'(TOTAL-1)) begin
          state_d = S_DONE;
        end else begin
          rd_d    = rd_q + IDX_W'(1);
          wdata_d = smp_q[rd_d];
          issue   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (issue) begin
      wr_d    = 1'b1;
      addr_d  = ptr_q;
      ptr_d   = ptr_q + ADDR_W'(1);
      count_d = count_q + 16'd1;
      if (ptr_q == '1) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= BASE_A;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      clr_q   <= '0;
      slot_q  <= '0;
      rd_q    <= '0;
      chip_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      clr_q   <= clr_d;
      slot_q  <= slot_d;
      rd_q    <= rd_d;
      chip_q  <= 1'b1;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      rdy_q   <= (state_d == S_CAPTURE);
    end
  end

  assign bus.in_ready       = rdy_q;
  assign bus.ocm1_writedata = wdata_q;
  assign bus.ocm1_addr      = addr_q;
  assign bus.ocm1_chip      = chip_q;
  assign bus.ocm1_clk_enab  = wr_q;
  assign bus.ocm1_write     = wr_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign overflow           = ovf_q;
  assign count              = count_q;

endmodule

// File: tb/tb_aux_ocm_writer.sv
// Bench for aux_ocm_writer: two instances (low base, wrapping base)
// checked against a frame-level model of expected OCM writes.
module tb_aux_ocm_writer;

  localparam int DW    = 8;
  localparam int AW    = 17;
  localparam int CH    = 2;
  localparam int FL    = 4;
  localparam int CW    = 8;
  localparam int BA    = 16;
  localparam int BB    = 131068;
  localparam int TOT   = CH * FL;
  localparam int ASPAN = 1 << AW;
  localparam int DBW   = CH * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_start, a_clr, a_busy, a_done, a_ovf;
  logic        b_start, b_clr, b_busy, b_done, b_ovf;
  logic [15:0] a_cnt, b_cnt;

  aux_ocm_writer_if #(.DATA_W(DW), .ADDR_W(AW), .CHANNELS(CH)) ia ();
  aux_ocm_writer_if #(.DATA_W(DW), .ADDR_W(AW), .CHANNELS(CH)) ib ();

  aux_ocm_writer #(
    .DATA_W(DW), .ADDR_W(AW), .CHANNELS(CH), .FRAME_LEN(FL),
    .CLEAR_WORDS(CW), .BASE_ADDR(BA)
  ) dut_a (
    .clk(clk), .reset(rst_n), .start(a_start), .clear_en(a_clr),
    .bus(ia), .busy(a_busy), .done(a_done), .overflow(a_ovf),
    .count(a_cnt)
  );

  aux_ocm_writer #(
    .DATA_W(DW), .ADDR_W(AW), .CHANNELS(CH), .FRAME_LEN(FL),
    .CLEAR_WORDS(CW), .BASE_ADDR(BB)
  ) dut_b (
    .clk(clk), .reset(rst_n), .start(b_start), .clear_en(b_clr),
    .bus(ib), .busy(b_busy), .done(b_done), .overflow(b_ovf),
    .count(b_cnt)
  );

  int total = 0;
  int bad   = 0;
  int sel   = 0;

  int m_ptr [2];
  int m_cnt [2];
  int m_ovf [2];
  int base  [2];

  logic          o_wr, o_en, o_chip, o_rdy, o_busy, o_done, o_ovf;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic [15:0]   o_cnt;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (sel == 0) begin
      o_wr = ia.ocm1_write;   o_en = ia.ocm1_clk_enab;
      o_chip = ia.ocm1_chip;  o_rdy = ia.in_ready;
      o_addr = ia.ocm1_addr;  o_data = ia.ocm1_writedata;
      o_busy = a_busy; o_done = a_done; o_ovf = a_ovf; o_cnt = a_cnt;
    end else begin
      o_wr = ib.ocm1_write;   o_en = ib.ocm1_clk_enab;
      o_chip = ib.ocm1_chip;  o_rdy = ib.in_ready;
      o_addr = ib.ocm1_addr;  o_data = ib.ocm1_writedata;
      o_busy = b_busy; o_done = b_done; o_ovf = b_ovf; o_cnt = b_cnt;
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
  endtask

  task automatic drv(input logic st, input logic cl, input logic dv,
                     input logic [DBW-1:0] d);
    a_start = (sel == 0) & st;  a_clr = (sel == 0) & cl;
    b_start = (sel == 1) & st;  b_clr = (sel == 1) & cl;
    ia.in_dv = (sel == 0) & dv;
    ib.in_dv = (sel == 1) & dv;
    ia.in_data = d;
    ib.in_data = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = base[i];
      m_cnt[i] = 0;
      m_ovf[i] = 0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wr"},   64'(o_wr),   64'd0);
    chk({tag, "_en"},   64'(o_en),   64'd0);
    chk({tag, "_chip"}, 64'(o_chip), 64'd0);
    chk({tag, "_data"}, 64'(o_data), 64'd0);
    chk({tag, "_addr"}, 64'(o_addr), 64'd0);
    chk({tag, "_cnt"},  64'(o_cnt),  64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_ovf"},  64'(o_ovf),  64'd0);
    chk({tag, "_rdy"},  64'(o_rdy),  64'd0);
  endtask

  // Zeroing pass; junk in_dv and a stray start are applied throughout
  task automatic do_clear();
    drv(1'b1, 1'b1, 1'b1, DBW'($urandom));
    step();
    m_ptr[sel] = base[sel];
    m_cnt[sel] = 0;
    m_ovf[sel] = 0;
    for (int i = 0; i < CW; i++) begin
      drv(1'(i == 3), 1'($urandom_range(0, 1)), 1'b1, DBW'($urandom));
      chk("clr_wr",   64'(o_wr),   64'd1);
      chk("clr_en",   64'(o_en),   64'd1);
      chk("clr_addr", 64'(o_addr), 64'((base[sel] + i) % ASPAN));
      chk("clr_data", 64'(o_data), 64'd0);
      chk("clr_cnt",  64'(o_cnt),  64'd0);
      chk("clr_ovf",  64'(o_ovf),  64'd0);
      chk("clr_rdy",  64'(o_rdy),  64'd0);
      step();
    end
    drv(1'b0, 1'b0, 1'b0, '0);
    chk("clr_then_rdy", 64'(o_rdy), 64'd1);
    chk("clr_then_wr",  64'(o_wr),  64'd0);
  endtask

  // One frame; rst_at >= 0 pulls reset on that drain write
  task automatic do_frame(input bit from_idle, input int rst_at,
                          input bit fixed);
    logic [DW-1:0]  smp [FL][CH];
    logic [DBW-1:0] d;
    int             last;
    last = 0;
    if (from_idle) begin
      drv(1'b1, 1'b0, 1'b0, '0);
      step();
      drv(1'b0, 1'b0, 1'b0, '0);
      chk("cap_rdy",  64'(o_rdy),  64'd1);
      chk("cap_busy", 64'(o_busy), 64'd1);
    end
    for (int s = 0; s < FL; s++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        drv(1'b0, 1'b0, 1'b0, DBW'($urandom));
        step();
        chk("gap_wr",  64'(o_wr),  64'd0);
        chk("gap_rdy", 64'(o_rdy), 64'd1);
      end
      for (int c = 0; c < CH; c++) begin
        if (fixed) smp[s][c] = DW'(c * 16 + s + 1);
        else       smp[s][c] = DW'($urandom);
        d[c*DW +: DW] = smp[s][c];
      end
      drv(1'b0, 1'b0, 1'b1, d);
      step();
      if (s < FL - 1) chk("acc_rdy", 64'(o_rdy), 64'd1);
    end
    for (int k = 0; k < TOT; k++) begin
      drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), DBW'($urandom));
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        sample();
        chk_reset("rst_drain");
        drv(1'b0, 1'b0, 1'b0, '0);
        step();
        chk("rst_hold_wr", 64'(o_wr), 64'd0);
        rst_n = 1'b1;
        model_reset();
        step();
        chk("rst_rel_chip", 64'(o_chip), 64'd1);
        chk("rst_rel_busy", 64'(o_busy), 64'd0);
        chk("rst_rel_wr",   64'(o_wr),   64'd0);
        return;
      end
      chk("drn_wr",   64'(o_wr),   64'd1);
      chk("drn_en",   64'(o_en),   64'd1);
      chk("drn_addr", 64'(o_addr), 64'(m_ptr[sel]));
      chk("drn_data", 64'(o_data), 64'(smp[k % FL][k / FL]));
      last = m_ptr[sel];
      m_ptr[sel] = (m_ptr[sel] + 1) % ASPAN;
      if (m_ptr[sel] == 0) m_ovf[sel] = 1;
      m_cnt[sel] = (m_cnt[sel] + 1) % 65536;
      chk("drn_cnt",  64'(o_cnt),  64'(m_cnt[sel]));
      chk("drn_ovf",  64'(o_ovf),  64'(m_ovf[sel]));
      chk("drn_rdy",  64'(o_rdy),  64'd0);
      chk("drn_done", 64'(o_done), 64'd0);
      step();
    end
    drv(1'b0, 1'b0, 1'b0, '0);
    chk("done_pulse", 64'(o_done), 64'd1);
    chk("done_wr",    64'(o_wr),   64'd0);
    chk("done_addr",  64'(o_addr), 64'(last));
    chk("done_busy",  64'(o_busy), 64'd1);
    step();
    chk("idle_done", 64'(o_done), 64'd0);
    chk("idle_busy", 64'(o_busy), 64'd0);
    chk("idle_cnt",  64'(o_cnt),  64'(m_cnt[sel]));
    chk("idle_ovf",  64'(o_ovf),  64'(m_ovf[sel]));
  endtask

  initial begin
    base[0] = BA;
    base[1] = BB;
    model_reset();
    sel = 0;
    drv(1'b0, 1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1 sample();
    chk_reset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("por_chip", 64'(o_chip), 64'd1);
    chk("por_busy", 64'(o_busy), 64'd0);

    sel = 0;
    do_clear();
    do_frame(1'b0, -1, 1'b1);
    chk("first_cnt", 64'(o_cnt), 64'd8);
    do_frame(1'b1, -1, 1'b0);
    chk("append_cnt", 64'(o_cnt), 64'd16);
    do_clear();
    do_frame(1'b0, 2, 1'b0);
    do_frame(1'b1, -1, 1'b0);
    chk("post_rst_cnt", 64'(o_cnt), 64'd8);

    sel = 1;
    do_frame(1'b1, -1, 1'b1);
    chk("wrap_ovf", 64'(o_ovf), 64'd1);
    do_frame(1'b1, -1, 1'b0);
    chk("sticky_ovf", 64'(o_ovf), 64'd1);
    do_clear();
    do_frame(1'b0, -1, 1'b0);

    sel = 0;
    for (int n = 0; n < 4; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_clear();
        do_frame(1'b0, -1, 1'b0);
      end else begin
        do_frame(1'b1, -1, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aux_ocm_writer.md
AUX_OCM_WRITER -- requirements
Module: aux_ocm_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the sample and OCM word width.
REQ-002 SHALL have parameter ADDR_W, default 17, meaning the OCM address width.
REQ-003 SHALL have parameter CHANNELS, default 2, meaning the number of parallel output lanes captured per sample (>=1).
REQ-004 SHALL have parameter FRAME_LEN, default 16, meaning the samples captured per frame (>=1).
REQ-005 SHALL have parameter CLEAR_WORDS, default 4001, meaning the words zeroed by a clear pass (>=1).
REQ-006 SHALL have parameter BASE_ADDR, default 0, meaning the first OCM address used.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port reset, input, 1, an asynchronous, active-low reset (asserted at 0).
REQ-009 SHALL have port start, input, 1, a one-cycle request to run one frame.
REQ-010 SHALL have port clear_en, input, 1, sampled with start; 1 requests a clear pass and rewinds the address.
REQ-011 SHALL have port in_dv, input, 1, marking a valid sample.
REQ-012 SHALL have port in_data, input, CHANNELS*DATA_W, where lane c = in_data[c*DATA_W +: DATA_W].
REQ-013 SHALL have port in_ready, output, 1, high only in CAPTURE.
REQ-014 SHALL have ports ocm1_writedata (DATA_W) and ocm1_addr (ADDR_W), outputs, giving the OCM write word and address.
REQ-015 SHALL have ports ocm1_chip, ocm1_clk_enab and ocm1_write, outputs, 1 bit each, as OCM controls.
REQ-016 SHALL have ports busy, done and overflow, outputs, 1 bit each, and port count, output, 16 bits.

Function
REQ-017 SHALL implement states IDLE, CLEAR, CAPTURE, DRAIN and DONE; all outputs SHALL be registered.
REQ-018 IDLE: on start=1, SHALL go to CLEAR if clear_en=1, else to CAPTURE; start SHALL be ignored outside IDLE.
REQ-019 On an accepted start with clear_en=1, SHALL set the address pointer to BASE_ADDR, and clear count and overflow.
REQ-020 On an accepted start with clear_en=0, SHALL keep the address pointer, count and overflow (append mode).
REQ-021 CLEAR: SHALL write 0 once per cycle to BASE_ADDR .. BASE_ADDR+CLEAR_WORDS-1, reload the pointer with BASE_ADDR, then go to CAPTURE.
REQ-022 CAPTURE: each cycle with in_dv=1 SHALL store all CHANNELS lanes in sample slot k (k=0..FRAME_LEN-1); with in_dv=0 it SHALL hold.
REQ-023 Acceptance of sample FRAME_LEN-1 SHALL move to DRAIN on the next cycle; in_dv outside CAPTURE SHALL be ignored.
REQ-024 DRAIN: SHALL issue exactly one write per cycle, with no bubbles, channel-major: ch0 s0..sN-1, then ch1, and so on.
REQ-025 DRAIN: each write SHALL use the current pointer, then increment it; after CHANNELS*FRAME_LEN writes SHALL go to DONE.
REQ-026 The first DRAIN write SHALL appear on ocm1_write 1 cycle after the last sample is accepted.
REQ-027 DONE: done SHALL be high for exactly 1 cycle, then the block SHALL return to IDLE.
REQ-028 ocm1_write and ocm1_clk_enab SHALL be 1 only on cycles carrying a CLEAR or DRAIN write; ocm1_chip SHALL be 1 whenever out of reset.
REQ-029 ocm1_writedata and ocm1_addr SHALL be valid in the same cycle as ocm1_write=1, and SHALL hold their value otherwise.
REQ-030 The pointer SHALL wrap modulo 2^ADDR_W; a wrap SHALL set overflow, which stays sticky until reset or a clearing start.
REQ-031 count SHALL increment once per DRAIN write (CLEAR writes not counted), wrapping modulo 2^16.
REQ-032 busy SHALL be 1 in every state except IDLE.

Reset
REQ-033 Asserting reset SHALL immediately force IDLE, pointer=BASE_ADDR, and outputs ocm1_write=0, ocm1_clk_enab=0, ocm1_chip=0, ocm1_writedata=0, ocm1_addr=0, count=0, busy=0, done=0, overflow=0, in_ready=0.
REQ-034 Reset mid-CLEAR, mid-CAPTURE or mid-DRAIN SHALL abandon the frame with no further writes; buffer contents need not be cleared.

Verification (CHANNELS=2, FRAME_LEN=4, CLEAR_WORDS=8, BASE_ADDR=16, ADDR_W=17)
REQ-035 Scenario: start with clear_en=1 -> zeros written to addresses 16..23 on 8 consecutive cycles, then in_ready=1.
REQ-036 Scenario: samples {ch1,ch0}={0x11,0x01},{0x12,0x02},{0x13,0x03},{0x14,0x04} -> writes 01,02,03,04,11,12,13,14 to addresses 16..23 on 8 consecutive cycles, followed by a done pulse and count=8.
REQ-037 Scenario: second start with clear_en=0 and 4 samples -> writes at addresses 24..31 and count=16.
REQ-038 Scenario: BASE_ADDR=131068, no clear, 1 frame -> addresses 131068..131071, then 0..3, with overflow=1.
REQ-039 Scenario: reset pulled low on the 3rd DRAIN write -> ocm1_write=0 at once, with all outputs at their reset values; a later start works normally.
REQ-040 Scenario: start pulsed during DRAIN, plus in_dv during CLEAR -> both ignored, with write order and count unchanged.
